// File: rtl/t05_sram_mw_arbiter.sv
// Round-robin arbiter that splits multi-word client requests into single-word
// SRAM transactions toward the wishbone manager and reassembles read data.
module t05_sram_mw_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_WORDS = 5,
  parameter int LW        = $clog2(MAX_WORDS + 1)
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic [N_CLIENTS-1:0]              req,
  input  logic [N_CLIENTS-1:0]              req_we,
  input  logic [N_CLIENTS*AW-1:0]           req_addr,
  input  logic [N_CLIENTS*LW-1:0]           req_len,
  input  logic [N_CLIENTS*MAX_WORDS*DW-1:0] req_wdata,
  output logic [N_CLIENTS-1:0]              gnt,
  output logic [N_CLIENTS-1:0]              done,
  output logic [MAX_WORDS*DW-1:0]           rd_data,
  output logic                              busy,
  output logic                              wr_en,
  output logic                              r_en,
  output logic [AW-1:0]                     addr,
  output logic [DW-1:0]                     wdata,
  output logic [DW/8-1:0]                   select,
  input  logic                              busy_o,
  input  logic [DW-1:0]                     sram_rdata
);

  localparam int PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int KW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q;
  logic [PW-1:0]   win_q;
  logic            we_q;
  logic [AW-1:0]   base_q;
  logic [KW-1:0]   last_q;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   wbuf_q [MAX_WORDS];
  logic [DW-1:0]   rd_q   [MAX_WORDS];

  // Per-client views of the flattened request buses
  logic [AW-1:0]   cl_addr  [N_CLIENTS];
  logic [LW-1:0]   cl_len   [N_CLIENTS];
  logic [DW-1:0]   cl_wdata [N_CLIENTS][MAX_WORDS];

  generate
    for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_client
      assign cl_addr[gi] = req_addr[gi*AW +: AW];
      assign cl_len[gi]  = req_len[gi*LW +: LW];
      for (genvar gk = 0; gk < MAX_WORDS; gk++) begin : g_word
        assign cl_wdata[gi][gk] = req_wdata[(gi*MAX_WORDS+gk)*DW +: DW];
      end
    end
  endgenerate

  // Round-robin search: first requester at or above rr_q, wrapping around
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic [LW-1:0]   win_len;
  logic [KW-1:0]   win_last;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      cand = (int'(rr_q) + i >= N_CLIENTS) ? PW'(int'(rr_q) + i - N_CLIENTS)
                                           : PW'(int'(rr_q) + i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Zero-length requests still perform one access; oversize ones clamp
  always_comb begin
    win_len = cl_len[win_idx];
    if (win_len == '0) begin
      win_last = '0;
    end else if (int'(win_len) > MAX_WORDS) begin
      win_last = KW'(MAX_WORDS - 1);
    end else begin
      win_last = KW'(win_len - 1'b1);
    end
  end

  logic grant;
  logic word_end;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    grant    = 1'b0;
    word_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant   = 1'b1;
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_ACK;
      S_ACK: begin
        if (busy_o) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!busy_o) begin
          word_end = 1'b1;
          if (k_q == last_q) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_q   <= '0;
      win_q  <= '0;
      we_q   <= 1'b0;
      base_q <= '0;
      last_q <= '0;
      for (int k = 0; k < MAX_WORDS; k++) begin
        wbuf_q[k] <= '0;
        rd_q[k]   <= '0;
      end
    end else begin
      if (grant) begin
        win_q  <= win_idx;
        we_q   <= req_we[win_idx];
        base_q <= cl_addr[win_idx];
        last_q <= win_last;
        for (int k = 0; k < MAX_WORDS; k++) begin
          wbuf_q[k] <= cl_wdata[win_idx][k];
          rd_q[k]   <= '0;
        end
      end
      if (word_end && !we_q) begin
        rd_q[k_q] <= sram_rdata;
      end
      if (state_q == S_DONE) begin
        rr_q <= (int'(win_q) == N_CLIENTS - 1) ? '0 : win_q + 1'b1;
      end
    end
  end

  // addr/wdata derive from registers that only change at grant or word advance,
  // so they hold their last value while idle
  assign addr   = base_q + AW'(k_q);
  assign wdata  = wbuf_q[k_q];
  assign busy   = (state_q == S_ISSUE) || (state_q == S_ACK) || (state_q == S_WAIT);
  assign wr_en  = (state_q == S_ISSUE) && we_q;
  assign r_en   = (state_q == S_ISSUE) && !we_q;
  assign select = (state_q == S_ISSUE) ? '1 : '0;

  generate
    for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_pulse
      assign gnt[gi]  = (state_q == S_ISSUE) && (k_q == '0) && (win_q == PW'(gi));
      assign done[gi] = (state_q == S_DONE) && (win_q == PW'(gi));
    end
    for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_rd
      assign rd_data[gi*DW +: DW] = rd_q[gi];
    end
  endgenerate

endmodule
